// File: rtl/imem_program_loader_if.sv
// Instruction-loader stream and instruction-memory write bus.
// master drives the instruction fields; slave is the loader.
interface imem_program_loader_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [2:0]        kind;
   logic [2:0]        alu_fn;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [15:0]       imm;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic [ADDR_W:0]   count;
   logic              done;
   logic              err;
   logic              cpu_hold;

   modport master (
      output start, in_valid, in_last, kind, alu_fn,
      output rs, rt, rd, imm,
      input  in_ready, im_we, im_addr, im_wdata,
      input  count, done, err, cpu_hold
   );

   modport slave (
      input  start, in_valid, in_last, kind, alu_fn,
      input  rs, rt, rd, imm,
      output in_ready, im_we, im_addr, im_wdata,
      output count, done, err, cpu_hold
   );
endinterface

// File: rtl/imem_program_loader.sv
// Encodes symbolic instructions into MIPS words and loads them into imem.
// IMEM_ILLEGAL_TRAP_EN: illegal encodings stop the load instead of writing a nop.
module imem_program_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input logic                 clk,
   input logic                 reset,
   imem_program_loader_if.slave bus
);

`ifdef IMEM_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [ADDR_W:0] LAST_W = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t            state_q;
   logic              ready_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W:0]   count_q;
   logic              done_q;
   logic              err_q;
   logic              hold_q;

   logic [5:0]  funct;
   logic        bad_fn;
   logic        bad;
   logic [31:0] enc;

   always_comb begin
      funct  = 6'h00;
      bad_fn = 1'b0;
      case (bus.alu_fn)
         3'd0:    funct = 6'h20;
         3'd1:    funct = 6'h22;
         3'd2:    funct = 6'h24;
         3'd3:    funct = 6'h25;
         3'd4:    funct = 6'h2A;
         default: bad_fn = 1'b1;
      endcase
   end

   always_comb begin
      bad = 1'b0;
      enc = 32'h0;
      case (bus.kind)
         3'd0: begin
            enc = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, funct};
            bad = bad_fn;
         end
         3'd1:    enc = {6'h08, bus.rs, bus.rt, bus.imm};
         3'd2:    enc = {6'h04, bus.rs, bus.rt, bus.imm};
         3'd3:    enc = {6'h02, bus.rs, bus.rt, bus.imm};
         3'd4:    enc = {6'h23, bus.rs, bus.rt, bus.imm};
         3'd5:    enc = {6'h2B, bus.rs, bus.rt, bus.imm};
         default: bad = 1'b1;
      endcase
      if (bad) enc = 32'h0;
   end

   // count doubles as the write pointer; it is one bit wider so it never wraps
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 1'b1;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q <= LOAD;
                  ready_q <= 1'b1;
                  count_q <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  hold_q  <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  if (bad && TRAP) begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     we_q    <= 1'b1;
                     addr_q  <= count_q[ADDR_W-1:0];
                     wdata_q <= enc;
                     count_q <= count_q + ONE;
                     if (bad) err_q <= 1'b1;
                     if (bus.in_last || count_q == LAST_W) begin
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready = ready_q;
   assign bus.im_we    = we_q;
   assign bus.im_addr  = addr_q;
   assign bus.im_wdata = wdata_q;
   assign bus.count    = count_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomised and directed bench for imem_program_loader,
// checked every cycle against a behavioural load model.
module tb_imem_program_loader;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

`ifdef IMEM_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imem_program_loader_if #(.ADDR_W(AW)) bus ();

   imem_program_loader #(
      .DEPTH (DEPTH),
      .ADDR_W(AW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {illegal, word} from the instruction-set rules
   function automatic logic [32:0] ref_enc(
      input logic [2:0] k, input logic [2:0] fn,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm);
      logic [29:0] fts;
      logic [29:0] ops;
      logic [5:0]  op;
      fts = {6'h2A, 6'h25, 6'h24, 6'h22, 6'h20};
      ops = {6'h2B, 6'h23, 6'h02, 6'h04, 6'h08};
      if (k == 3'd0) begin
         if (fn > 3'd4) return {1'b1, 32'h0};
         return {1'b0, 6'h00, rs, rt, rd, 5'd0, fts[int'(fn)*6 +: 6]};
      end
      if (k > 3'd5) return {1'b1, 32'h0};
      op = ops[(int'(k)-1)*6 +: 6];
      return {1'b0, op, rs, rt, imm};
   endfunction

   bit          m_loading, m_we, m_done, m_err, m_hold;
   int          m_count;
   logic [AW-1:0] m_addr;
   logic [31:0] m_data;

   always @(posedge clk or posedge reset) begin : model
      logic [32:0] e;
      int nc;
      if (reset) begin
         m_loading <= 0; m_we <= 0; m_addr <= '0; m_data <= 0;
         m_count <= 0; m_done <= 0; m_err <= 0; m_hold <= 1;
      end else begin
         m_we <= 0;
         if (!m_loading) begin
            if (bus.start) begin
               m_loading <= 1; m_count <= 0; m_done <= 0;
               m_err <= 0; m_hold <= 1;
            end
         end else if (bus.in_valid) begin
            e = ref_enc(bus.kind, bus.alu_fn, bus.rs, bus.rt,
                        bus.rd, bus.imm);
            if (e[32] && TRAP) begin
               m_err <= 1; m_loading <= 0; m_done <= 1;
            end else begin
               nc = m_count + 1;
               m_we <= 1;
               m_addr <= AW'(m_count);
               m_data <= e[31:0];
               m_count <= nc;
               if (e[32]) m_err <= 1;
               if (bus.in_last || nc == DEPTH) begin
                  m_loading <= 0; m_done <= 1; m_hold <= 0;
               end
            end
         end
      end
   end

   bit cmp_on = 0;

   always @(negedge clk) begin
      if (cmp_on) begin
         check("in_ready", 32'(bus.in_ready), 32'(m_loading));
         check("im_we", 32'(bus.im_we), 32'(m_we));
         if (m_we) begin
            check("im_addr", 32'(bus.im_addr), 32'(m_addr));
            check("im_wdata", bus.im_wdata, m_data);
         end
         check("count", 32'(bus.count), 32'(m_count));
         check("done", 32'(bus.done), 32'(m_done));
         check("err", 32'(bus.err), 32'(m_err));
         check("cpu_hold", 32'(bus.cpu_hold), 32'(m_hold));
      end
   end

   logic [31:0] wmem [DEPTH];
   int          tot_we = 0;
   int          wlog_addr [$];

   always @(negedge clk) begin
      if (bus.im_we === 1'b1) begin
         wmem[bus.im_addr] <= bus.im_wdata;
         wlog_addr.push_back(int'(bus.im_addr));
         tot_we <= tot_we + 1;
      end
   end

   int base = 0;

   task automatic pulse_start();
      @(negedge clk);
      bus.in_valid = 0;
      bus.start = 1;
      base = tot_we;
      @(negedge clk);
      bus.start = 0;
   endtask

   task automatic drive(logic [2:0] k, logic [2:0] fn, logic [4:0] rs,
                        logic [4:0] rt, logic [4:0] rd, logic [15:0] imm,
                        logic last);
      int n;
      @(negedge clk);
      bus.kind = k; bus.alu_fn = fn; bus.rs = rs; bus.rt = rt;
      bus.rd = rd; bus.imm = imm; bus.in_last = last; bus.in_valid = 1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!bus.in_ready && n < 50);
      check("accept", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      bus.in_valid = 0;
      check("done_reached", 32'(bus.done), 32'd1);
      #1;
   endtask

   task automatic drive_rand(logic last);
      drive(3'($urandom % 6), 3'($urandom % 5), 5'($urandom),
            5'($urandom), 5'($urandom), 16'($urandom), last);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 0; bus.in_valid = 0; bus.in_last = 0;
      bus.kind = 0; bus.alu_fn = 0; bus.rs = 0; bus.rt = 0;
      bus.rd = 0; bus.imm = 0;
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      cmp_on = 1;
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_hold", 32'(bus.cpu_hold), 32'd1);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wdata", bus.im_wdata, 32'h0);
      check("rst_done", 32'(bus.done), 32'd0);

      // single addi with last
      pulse_start();
      drive(3'd1, 3'd0, 5'd0, 5'd8, 5'd0, 16'd5, 1'b1);
      wait_done();
      check("t1_word", wmem[0], 32'h20080005);
      check("t1_count", 32'(bus.count), 32'd1);
      check("t1_hold", 32'(bus.cpu_hold), 32'd0);

      // R add then j
      pulse_start();
      drive(3'd0, 3'd0, 5'd8, 5'd9, 5'd10, 16'd0, 1'b0);
      drive(3'd3, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0010, 1'b1);
      wait_done();
      check("t2_w0", wmem[0], 32'h01095020);
      check("t2_w1", wmem[1], 32'h08000010);

      // lw with a valid gap
      pulse_start();
      drive(3'd4, 3'd0, 5'd29, 5'd8, 5'd0, 16'd4, 1'b0);
      idle();
      idle();
      drive(3'd4, 3'd0, 5'd29, 5'd8, 5'd0, 16'd4, 1'b1);
      wait_done();
      check("t3_word", wmem[0], 32'h8FA80004);
      check("t3_nwe", 32'(tot_we - base), 32'd2);

      // overflow attempt: DEPTH+3 words, no last
      pulse_start();
      for (int i = 0; i < DEPTH; i++) drive_rand(1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1;
         check("t4_noready", 32'(bus.in_ready), 32'd0);
      end
      wait_done();
      check("t4_count", 32'(bus.count), 32'd64);
      check("t4_nwe", 32'(tot_we - base), 32'd64);
      check("t4_lastaddr", 32'(wlog_addr[tot_we - 1]), 32'd63);
      check("t4_first", 32'(wlog_addr[base]), 32'd0);

      // illegal kind mid-program
      pulse_start();
      drive(3'd1, 3'd0, 5'd1, 5'd2, 5'd0, 16'd7, 1'b0);
      drive(3'd7, 3'd0, 5'd1, 5'd2, 5'd3, 16'd7, 1'b0);
      if (TRAP) begin
         wait_done();
         check("t5_err", 32'(bus.err), 32'd1);
         check("t5_hold", 32'(bus.cpu_hold), 32'd1);
         check("t5_nwe", 32'(tot_we - base), 32'd1);
      end else begin
         drive(3'd1, 3'd0, 5'd3, 5'd4, 5'd0, 16'd9, 1'b1);
         wait_done();
         check("t5_nop", wmem[1], 32'h0);
         check("t5_err", 32'(bus.err), 32'd1);
         check("t5_count", 32'(bus.count), 32'd3);
         check("t5_hold", 32'(bus.cpu_hold), 32'd0);
      end

      // reset in the middle of a load
      pulse_start();
      for (int i = 0; i < 3; i++) drive_rand(1'b0);
      @(negedge clk);
      bus.in_valid = 0;
      reset = 1;
      #1;
      check("t6_count", 32'(bus.count), 32'd0);
      check("t6_hold", 32'(bus.cpu_hold), 32'd1);
      check("t6_we", 32'(bus.im_we), 32'd0);
      @(negedge clk);
      reset = 0;
      pulse_start();
      drive_rand(1'b1);
      wait_done();
      check("t6_addr0", 32'(wlog_addr[base]), 32'd0);
      check("t6_count1", 32'(bus.count), 32'd1);

      // random loads, including illegal fields and stray start pulses
      for (int ld = 0; ld < 8; ld++) begin
         pulse_start();
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!m_loading) break;
            bus.in_valid = ($urandom % 4) != 0;
            bus.kind = ($urandom % 12 == 0) ? 3'(6 + $urandom % 2)
                                            : 3'($urandom % 6);
            bus.alu_fn = ($urandom % 12 == 0) ? 3'(5 + $urandom % 3)
                                              : 3'($urandom % 5);
            bus.rs = 5'($urandom); bus.rt = 5'($urandom);
            bus.rd = 5'($urandom); bus.imm = 16'($urandom);
            bus.in_last = ($urandom % 20) == 0;
            bus.start = ($urandom % 10) == 0;
         end
         bus.in_valid = 0;
         bus.start = 0;
         check("rnd_done", 32'(bus.done), 32'd1);
         idle();
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
